// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if -- data-memory request channel between the MEM-stage
// access controller and the memory/bus side.
//
// Signals:
//   data_req      master->slave  request valid, held until data_addr_ok
//   data_wr       master->slave  1 = store, 0 = load
//   data_addr     master->slave  access address
//   data_wdata    master->slave  store data
//   data_strb     master->slave  byte enables
//   data_addr_ok  slave->master  request accepted
//   data_data_ok  slave->master  response (read data / write ack)
//   data_rdata    slave->master  read return data
//
// Modports: master (controller side), slave (memory side).
interface mem_access_ctrl_if;
    logic        data_req;
    logic        data_wr;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_strb;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_addr, data_wdata, data_strb,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_addr, data_wdata, data_strb,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl -- MEM-stage data memory access controller.
// Issues one load/store at a time over the request channel, stalls the
// pipeline while the access is in flight, and reports completion with a
// one-cycle MEM_result_valid pulse (suppressed when the instruction was
// flushed while outstanding).
//
// Optional feature: define MEM_TIMEOUT_EN to enable a watchdog that aborts
// an access after TIMEOUT cycles in REQ+WAIT and pulses timeout_err.
//
// Ports:
//   clk, resetn           clock, synchronous active-low reset
//   MEM_valid             instruction present in MEM stage
//   MEM_mem_read/_write   load / store request
//   MEM_addr/wdata/strb   access address, store data, byte enables
//   MEM_flush             kill the MEM-stage instruction
//   MEM_stall             hold upstream, bubble MEM/WB
//   MEM_result_valid      one-cycle completion pulse (not killed)
//   MEM_load_data         captured read data
//   timeout_err           one-cycle watchdog abort pulse
//   dbus                  request channel (master modport)
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     MEM_valid,
    input  logic                     MEM_mem_read,
    input  logic                     MEM_mem_write,
    input  logic [31:0]              MEM_addr,
    input  logic [31:0]              MEM_wdata,
    input  logic [3:0]               MEM_strb,
    input  logic                     MEM_flush,
    output logic                     MEM_stall,
    output logic                     MEM_result_valid,
    output logic [31:0]              MEM_load_data,
    output logic                     timeout_err,
    mem_access_ctrl_if.master        dbus
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic        wr_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  strb_q;
    logic        cancel_q;
    logic [31:0] load_q;
    logic        start;
    logic        busy;
    logic        expire;   // watchdog fires this cycle
    logic        tmo;      // current transaction was aborted

    assign start = MEM_valid & (MEM_mem_read | MEM_mem_write) & ~MEM_flush;
    assign busy  = (state_q == REQ) || (state_q == WAIT);

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic             tmo_q;

    assign expire = busy && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign tmo    = tmo_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else if (busy) begin
            cnt_q <= cnt_q + 1'b1;
            if (expire) tmo_q <= 1'b1;
        end
    end
`else
    assign expire = 1'b0;
    assign tmo    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = REQ;
            REQ: begin
                if (expire)                 state_d = DONE;
                else if (dbus.data_addr_ok) state_d = WAIT;
            end
            WAIT: begin
                if (expire || dbus.data_data_ok) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            strb_q   <= '1;
            cancel_q <= 1'b0;
            load_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                wr_q     <= MEM_mem_write;
                addr_q   <= MEM_addr;
                wdata_q  <= MEM_wdata;
                strb_q   <= MEM_strb;
                cancel_q <= 1'b0;
            end
            // A flush while outstanding only suppresses the result; the
            // request itself keeps draining on the bus.
            if (busy && MEM_flush) cancel_q <= 1'b1;
            if (expire)
                load_q <= '0;
            else if (state_q == WAIT && dbus.data_data_ok && !wr_q)
                load_q <= dbus.data_rdata;
        end
    end

    // Combinational outputs are gated with resetn so nothing is reported
    // while reset is asserted, even mid-transaction.
    assign MEM_stall        = resetn & (((state_q == IDLE) & start) | busy);
    assign MEM_result_valid = resetn & (state_q == DONE) & ~cancel_q & ~tmo;
    assign timeout_err      = resetn & (state_q == DONE) & tmo;
    assign MEM_load_data    = load_q;

    assign dbus.data_req   = resetn & (state_q == REQ);
    assign dbus.data_wr    = wr_q;
    assign dbus.data_addr  = addr_q;
    assign dbus.data_wdata = wdata_q;
    assign dbus.data_strb  = strb_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl -- randomized self-checking bench for mem_access_ctrl.
// Transactions are described by (kind, fields, accept delay, response delay,
// flush cycle); expected stall/request/result timing is computed from those
// numbers. Build with MEM_TIMEOUT_EN defined to also exercise the watchdog.
module tb_mem_access_ctrl;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TMO = 8;
`else
    localparam int unsigned TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        MEM_valid, MEM_mem_read, MEM_mem_write, MEM_flush;
    logic [31:0] MEM_addr, MEM_wdata;
    logic [3:0]  MEM_strb;
    logic        MEM_stall, MEM_result_valid, timeout_err;
    logic [31:0] MEM_load_data;

    always #5 clk = ~clk;

    mem_access_ctrl_if dbus();

    mem_access_ctrl #(.TIMEOUT(TMO)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .MEM_valid        (MEM_valid),
        .MEM_mem_read     (MEM_mem_read),
        .MEM_mem_write    (MEM_mem_write),
        .MEM_addr         (MEM_addr),
        .MEM_wdata        (MEM_wdata),
        .MEM_strb         (MEM_strb),
        .MEM_flush        (MEM_flush),
        .MEM_stall        (MEM_stall),
        .MEM_result_valid (MEM_result_valid),
        .MEM_load_data    (MEM_load_data),
        .timeout_err      (timeout_err),
        .dbus             (dbus)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] exp_load;   // model of the last captured read data

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        dbus.data_addr_ok = 1'($urandom);
        dbus.data_data_ok = 1'($urandom);
        dbus.data_rdata   = $urandom;
    endtask

    // One cycle in IDLE with inputs that must not start an access.
    task automatic idle_cycle();
        int unsigned k;
        k = $urandom_range(0, 2);
        MEM_valid     = (k != 0);
        MEM_mem_read  = (k != 1) && 1'($urandom);
        MEM_mem_write = (k != 1) && !MEM_mem_read;
        MEM_flush     = (k == 2);
        MEM_addr      = $urandom;
        noise();
        @(negedge clk);
        check("idle_stall", 32'(MEM_stall), 32'd0);
        check("idle_req", 32'(dbus.data_req), 32'd0);
        check("idle_rv", 32'(MEM_result_valid), 32'd0);
        check("idle_tmo", 32'(timeout_err), 32'd0);
        check("idle_load", MEM_load_data, exp_load);
        step();
    endtask

    // Full transaction: cycle 0 start, REQ for ad+1 cycles (accept on last),
    // WAIT for dd+1 cycles (response on last), then one DONE cycle.
    // flush_at selects a REQ/WAIT cycle index (1..ad+dd+2) to flush, 0 = none.
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic [31:0] rdata,
                           input int unsigned ad, input int unsigned dd, input int unsigned flush_at);
        int unsigned last;
        bit          cancel;
        last   = ad + dd + 2;
        cancel = (flush_at != 0) && (flush_at <= last);

        MEM_valid = 1'b1; MEM_mem_read = !wr; MEM_mem_write = wr; MEM_flush = 1'b0;
        MEM_addr = addr; MEM_wdata = wdata; MEM_strb = strb;
        noise();
        @(negedge clk);
        check("start_stall", 32'(MEM_stall), 32'd1);
        check("start_req", 32'(dbus.data_req), 32'd0);
        check("start_rv", 32'(MEM_result_valid), 32'd0);
        step();

        for (int unsigned c = 1; c <= last; c++) begin
            // Upstream fields change freely; the channel must hold latched values.
            MEM_addr = $urandom; MEM_wdata = $urandom; MEM_strb = 4'($urandom);
            MEM_mem_read = 1'($urandom); MEM_mem_write = !MEM_mem_read;
            MEM_flush = (c == flush_at);
            noise();
            if (c <= ad + 1) begin
                dbus.data_addr_ok = (c == ad + 1);
            end else begin
                dbus.data_data_ok = (c == last);
                if (c == last) dbus.data_rdata = rdata;
            end
            @(negedge clk);
            check("busy_stall", 32'(MEM_stall), 32'd1);
            check("busy_rv", 32'(MEM_result_valid), 32'd0);
            check("busy_req", 32'(dbus.data_req), 32'(c <= ad + 1));
            if (c <= ad + 1) begin
                check("req_wr", 32'(dbus.data_wr), 32'(wr));
                check("req_addr", dbus.data_addr, addr);
                check("req_wdata", dbus.data_wdata, wdata);
                check("req_strb", 32'(dbus.data_strb), 32'(strb));
            end
            step();
        end
        if (!wr) exp_load = rdata;

        // DONE: an eligible new instruction must not be started here.
        MEM_valid = 1'b1; MEM_mem_read = 1'b1; MEM_mem_write = 1'b0; MEM_flush = 1'b0;
        MEM_addr = $urandom;
        noise();
        @(negedge clk);
        check("done_stall", 32'(MEM_stall), 32'd0);
        check("done_req", 32'(dbus.data_req), 32'd0);
        check("done_rv", 32'(MEM_result_valid), 32'(!cancel));
        check("done_tmo", 32'(timeout_err), 32'd0);
        check("done_load", MEM_load_data, exp_load);
        step();
    endtask

    initial begin
        bit          wr;
        int unsigned ad, dd, fl, gap;

        resetn = 1'b0;
        MEM_valid = 1'b1; MEM_mem_read = 1'b1; MEM_mem_write = 1'b0; MEM_flush = 1'b0;
        MEM_addr = 32'h0000_0abc; MEM_wdata = 32'h1111_2222; MEM_strb = 4'h3;
        dbus.data_addr_ok = 1'b0; dbus.data_data_ok = 1'b0; dbus.data_rdata = '0;
        exp_load = '0;

        // Reset with a would-be start present on the inputs.
        repeat (3) begin
            noise();
            @(negedge clk);
            check("rst_stall", 32'(MEM_stall), 32'd0);
            check("rst_rv", 32'(MEM_result_valid), 32'd0);
            check("rst_tmo", 32'(timeout_err), 32'd0);
            check("rst_req", 32'(dbus.data_req), 32'd0);
            check("rst_wr", 32'(dbus.data_wr), 32'd0);
            check("rst_addr", dbus.data_addr, 32'd0);
            check("rst_wdata", dbus.data_wdata, 32'd0);
            check("rst_strb", 32'(dbus.data_strb), 32'hf);
            check("rst_load", MEM_load_data, 32'd0);
            step();
        end
        resetn = 1'b1;
        repeat (3) idle_cycle();

        // Minimum-latency load.
        run_txn(1'b0, 32'h0000_1000, 32'h0, 4'hf, 32'hCAFE_F00D, 0, 0, 0);
        check("load_result", MEM_load_data, 32'hCAFE_F00D);
        // Store with delayed accept; read data register must not change.
        run_txn(1'b1, 32'h0000_2004, 32'h1234_5678, 4'b0011, 32'h5555_AAAA, 5, 0, 0);
        // Flush during WAIT: response drains, result suppressed, data captured.
        run_txn(1'b0, 32'h0000_3000, 32'h0, 4'hf, 32'h0BAD_F00D, 0, 2, 3);
        // Back-to-back loads.
        run_txn(1'b0, 32'h0000_0010, 32'h0, 4'hf, 32'hA0A0_0010, 0, 0, 0);
        run_txn(1'b0, 32'h0000_0014, 32'h0, 4'hf, 32'hA0A0_0014, 1, 1, 0);

        // Reset while in WAIT, response arriving during and after reset.
        MEM_valid = 1'b1; MEM_mem_read = 1'b1; MEM_mem_write = 1'b0; MEM_flush = 1'b0;
        MEM_addr = 32'h0000_4000;
        dbus.data_addr_ok = 1'b0; dbus.data_data_ok = 1'b0;
        step();
        dbus.data_addr_ok = 1'b1;
        step();
        dbus.data_addr_ok = 1'b0;
        resetn = 1'b0; dbus.data_data_ok = 1'b1; dbus.data_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("rstw_stall", 32'(MEM_stall), 32'd0);
        check("rstw_rv", 32'(MEM_result_valid), 32'd0);
        step();
        resetn = 1'b1; MEM_valid = 1'b0;
        exp_load = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rstw_post_stall", 32'(MEM_stall), 32'd0);
            check("rstw_post_rv", 32'(MEM_result_valid), 32'd0);
            check("rstw_post_req", 32'(dbus.data_req), 32'd0);
            check("rstw_post_load", MEM_load_data, 32'd0);
            step();
            dbus.data_data_ok = 1'b0;
        end

`ifdef MEM_TIMEOUT_EN
        // Accept never arrives: abort after TMO cycles in REQ.
        MEM_valid = 1'b1; MEM_mem_read = 1'b1; MEM_mem_write = 1'b0; MEM_flush = 1'b0;
        MEM_addr = 32'h0000_0040;
        dbus.data_addr_ok = 1'b0; dbus.data_data_ok = 1'b0;
        for (int unsigned c = 0; c <= TMO + 1; c++) begin
            @(negedge clk);
            check("tmo_stall", 32'(MEM_stall), 32'(c <= TMO));
            check("tmo_req", 32'(dbus.data_req), 32'(c >= 1 && c <= TMO));
            check("tmo_err", 32'(timeout_err), 32'(c == TMO + 1));
            check("tmo_rv", 32'(MEM_result_valid), 32'd0);
            if (c == TMO + 1) check("tmo_load", MEM_load_data, 32'd0);
            step();
            MEM_valid = 1'b0;
        end
        exp_load = '0;
`endif

        for (int i = 0; i < 60; i++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) idle_cycle();
            wr = 1'($urandom);
            ad = $urandom_range(0, 2);
            dd = $urandom_range(0, 2);
            fl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, ad + dd + 2) : 0;
            run_txn(wr, $urandom, $urandom, 4'($urandom), $urandom, ad, dd, fl);
        end
        repeat (2) idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
